// File: rtl/axil_regcheck_master_pkg.sv
// axil_regcheck_master_pkg: FSM states, AXI response codes and the register test pattern.
package axil_regcheck_master_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_WR_RESP, ST_RD, ST_RD_RESP, ST_NEXT, ST_FINISH
  } state_e;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  // rotl(seed, idx) ^ idx within a 32- or 64-bit word; seed must already be zero-extended
  function automatic logic [63:0] pattern(input logic [63:0] seed, input logic [3:0] idx, input bit wide);
    logic [63:0] r;
    r = wide ? (seed << idx) | (seed >> (7'd64 - {3'b0, idx}))
             : ((seed << idx) | (seed >> (7'd32 - {3'b0, idx}))) & 64'h0000_0000_FFFF_FFFF;
    return r ^ {60'h0, idx};
  endfunction
endpackage

// File: rtl/axil_regcheck_timeout.sv
// axil_regcheck_timeout: handshake watchdog, expires on the TIMEOUT_CYCLES-th enabled cycle after load.
module axil_regcheck_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d = load_i ? '0 : (en_i && !expired_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= !rst_n_i ? '0 : cnt_d;
endmodule

// File: rtl/axil_regcheck_master.sv
// axil_regcheck_master: AXI4-Lite master that writes a seeded pattern to a register bank,
// reads it back, and reports mismatches, bad responses and handshake timeouts.
module axil_regcheck_master
  import axil_regcheck_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic                    mode,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [7:0]              err_count,
  output logic [3:0]              first_err_idx,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  localparam logic [3:0] LAST = 4'(NUM_REGS - 1);
  localparam int LG_BYTES = (DATA_WIDTH == 64) ? 3 : 2;
  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d, first_q, first_d;
  logic [7:0] err_q, err_d;
  logic mode_q, mode_d, rd_phase_q, rd_phase_d, pass_q, pass_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d, wdata_q, wdata_d, exp_data;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic aw_hs, w_hs, aw_all, w_all, waiting, expired, err_inc, abort, accept;
  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs = m_axi_wvalid && m_axi_wready;
  assign aw_all = aw_done_q || aw_hs;
  assign w_all = w_done_q || w_hs;
  assign waiting = state_q inside {ST_WR, ST_WR_RESP, ST_RD, ST_RD_RESP};
  assign accept = (state_q == ST_IDLE) && start;
  assign exp_data = DATA_WIDTH'(pattern(64'(seed_q), idx_q, DATA_WIDTH == 64));
  axil_regcheck_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (ACLK),
    .rst_n_i  (ARESETN),
    .load_i   ((state_d != state_q) || aw_hs || w_hs),
    .en_i     (waiting),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    mode_d = mode_q;
    seed_d = seed_q;
    rd_phase_d = rd_phase_q;
    pass_d = pass_q;
    err_inc = 1'b0;
    abort = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_WR;
        idx_d = '0;
        mode_d = mode;
        seed_d = seed;
        rd_phase_d = 1'b0;
        pass_d = 1'b0;
      end
      ST_WR: if (aw_all && w_all) state_d = ST_WR_RESP;
        else abort = expired && !aw_hs && !w_hs;
      ST_WR_RESP: if (m_axi_bvalid) begin
        err_inc = m_axi_bresp != RESP_OKAY;
        state_d = mode_q ? ST_NEXT : ST_RD;
      end else abort = expired;
      ST_RD: if (m_axi_arready) state_d = ST_RD_RESP;
        else abort = expired;
      ST_RD_RESP: if (m_axi_rvalid) begin
        err_inc = (m_axi_rresp != RESP_OKAY) || (m_axi_rdata != exp_data);
        state_d = ST_NEXT;
      end else abort = expired;
      // mode 1 wraps from the last write back to register 0 for the read phase
      ST_NEXT: if (idx_q == LAST) begin
        state_d = (mode_q && !rd_phase_q) ? ST_RD : ST_FINISH;
        idx_d = '0;
        rd_phase_d = 1'b1;
      end else begin
        idx_d = idx_q + 4'd1;
        state_d = (mode_q && rd_phase_q) ? ST_RD : ST_WR;
      end
      ST_FINISH: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      err_inc = 1'b1;
      state_d = ST_FINISH;
    end
    aw_done_d = (state_q == ST_WR) && (state_d == ST_WR) && aw_all;
    w_done_d = (state_q == ST_WR) && (state_d == ST_WR) && w_all;
    err_d = accept ? 8'd0 : (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    first_d = accept ? 4'hF : (err_inc && err_q == 8'd0) ? idx_q : first_q;
    if (state_d == ST_FINISH && state_q != ST_FINISH) pass_d = err_d == 8'd0;
    wdata_d = (state_d == ST_WR) ? DATA_WIDTH'(pattern(64'(seed_d), idx_d, DATA_WIDTH == 64)) : wdata_q;
    addr_d = (state_d == ST_WR || state_d == ST_RD) ? BASE_ADDR + (ADDR_WIDTH'(idx_d) << LG_BYTES) : addr_q;
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      first_q <= 4'hF;
      err_q <= '0;
      mode_q <= 1'b0;
      rd_phase_q <= 1'b0;
      pass_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      seed_q <= '0;
      wdata_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      first_q <= first_d;
      err_q <= err_d;
      mode_q <= mode_d;
      rd_phase_q <= rd_phase_d;
      pass_q <= pass_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      seed_q <= seed_d;
      wdata_q <= wdata_d;
      addr_q <= addr_d;
    end
  end
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_FINISH;
  assign pass = pass_q;
  assign err_count = err_q;
  assign first_err_idx = first_q;
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wdata = wdata_q;
  assign m_axi_wstrb = '1;
  assign m_axi_awvalid = (state_q == ST_WR) && !aw_done_q;
  assign m_axi_wvalid = (state_q == ST_WR) && !w_done_q;
  assign m_axi_bready = state_q == ST_WR_RESP;
  assign m_axi_arvalid = state_q == ST_RD;
  assign m_axi_rready = state_q == ST_RD_RESP;
endmodule

// File: doc/axil_regcheck_master.md
AXIL_REGCHECK_MASTER -- requirements
Module: axil_regcheck_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, AXI4-Lite data width; legal values 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-003 Parameter NUM_REGS, default 4, registers checked per run; legal range 1..16.
REQ-004 Parameter BASE_ADDR, default 32'h0, address of register 0.
REQ-005 Parameter TIMEOUT_CYCLES, default 256, maximum wait for any single handshake.
REQ-006 ACLK  in  1  sole clock; all logic on rising edge.
REQ-007 ARESETN  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  one-cycle run request; ignored while busy=1.
REQ-009 mode  in  1  0 = write/readback per register; 1 = write all registers, then read all.
REQ-010 seed  in  DATA_WIDTH  pattern seed; sampled together with mode on accepted start.
REQ-011 busy  out  1  run in progress.
REQ-012 done  out  1  one-cycle pulse at end of run.
REQ-013 pass  out  1  result of last run; valid from done until next accepted start.
REQ-014 err_count  out  8  mismatch plus bad-response plus timeout events; saturates at 255.
REQ-015 first_err_idx  out  4  index of first failing register; 4'hF if none.
REQ-016 m_axi_aw: awaddr out ADDR_WIDTH, awprot out 3, awvalid out 1, awready in 1.
REQ-017 m_axi_w: wdata out DATA_WIDTH, wstrb out DATA_WIDTH/8, wvalid out 1, wready in 1.
REQ-018 m_axi_b: bresp in 2, bvalid in 1, bready out 1.
REQ-019 m_axi_ar: araddr out ADDR_WIDTH, arprot out 3, arvalid out 1, arready in 1.
REQ-020 m_axi_r: rdata in DATA_WIDTH, rresp in 2, rvalid in 1, rready out 1.

Function
REQ-021 Register i is at BASE_ADDR + i*(DATA_WIDTH/8); the test pattern is P(i) = rotl(seed, i) XOR i, zero-extended.
REQ-022 awprot and arprot are 3'b000, and wstrb is all ones.
REQ-023 The FSM states are IDLE, WR, WR_RESP, RD, RD_RESP, NEXT, FINISH.
REQ-024 In IDLE, a start makes the next state WR with idx=0, and clears err_count and first_err_idx.
REQ-025 WR asserts awvalid and wvalid together; each valid drops individually on its own handshake; the FSM goes to WR_RESP once both handshakes have completed, in either order or the same cycle.
REQ-026 In WR_RESP, bready=1; a bvalid with bresp!=OKAY counts one error; mode 0 then goes to RD, and mode 1 goes to NEXT.
REQ-027 RD asserts arvalid until arready; RD_RESP asserts rready, and on rvalid counts one error if rresp!=OKAY or rdata!=P(idx).
REQ-028 In mode 1, after the write of idx=NUM_REGS-1, idx returns to 0 and the read phase runs RD/RD_RESP for every index.
REQ-029 NEXT increments idx; the FSM goes to FINISH after the last index of the final phase.
REQ-030 FINISH pulses done for one cycle, sets pass=(err_count==0), and returns to IDLE.
REQ-031 Each handshake wait runs a timeout counter; on reaching TIMEOUT_CYCLES it counts one error, deasserts all valid/ready signals, and goes to FINISH (abort).
REQ-032 first_err_idx latches idx only on the first error of a run.
REQ-033 Minimum latency with zero-wait slave, mode 0: each register takes 4 cycles (WR, WR_RESP, RD, RD_RESP) plus NEXT.

Reset
REQ-034 With ARESETN=0 at a clock edge, all valid/ready outputs are 0 and the state is IDLE.
REQ-035 With ARESETN=0 at a clock edge, busy=0, done=0, pass=0, err_count=0, first_err_idx=4'hF, and address/data outputs are 0.
REQ-036 Reset asserted mid-run abandons the run without a done pulse.

Structure
REQ-037 A shared package holds the state enum, OKAY/EXOKAY response constants, and the pattern function P.
REQ-038 One sub-module, axil_regcheck_timeout (load/enable counter with expiry flag), is instantiated once.

Verification
REQ-039 Mode 0, NUM_REGS=4, seed=32'h0101FFFF, echo-register slave with zero wait -> 4 write/read pairs at 0x0, 0x4, 0x8, 0xC; done; pass=1; err_count=0.
REQ-040 Mode 1, same slave -> 4 AW/W handshakes precede every AR; pass=1.
REQ-041 Slave corrupts rdata at register 2 -> err_count=1, first_err_idx=2, pass=0.
REQ-042 Slave returns bresp=2'b10 at register 1, plus randomised awready/wready skew -> err_count=1, first_err_idx=1, no handshake lost.
REQ-043 Slave never asserts arready, TIMEOUT_CYCLES=16 -> abort after 16 cycles; done; err_count=1; all valids low.
REQ-044 Reset mid-WR, then start again -> outputs at reset values; new run completes with pass=1; start pulsed while busy is ignored.
